pipeline_stage_reg: RTL and testbench
=====================================

Name: pipeline_stage_reg

Overview:
Generic, parametrised inter-stage pipeline register, successor to the fixed-field stage register. It carries one opaque payload word plus an exception code, with explicit valid/ready flow control instead of a bare stall input. An optional two-entry skid buffer registers the upstream ready, breaking the stall combinational path across stages. Sync clear and flush insert NOP bubbles (all-zero payload), as the existing pipeline does.

Parameters:
DATA_W, 128, payload width in bits (packed INST/PC/operands/etc.)
EX_W, 5, exception-code width
SKID, 1, 1 = two-entry skid buffer (registered in_ready); 0 = single register (combinational in_ready)

Ports:
clk  in  1  clock, rising edge
clr_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear, active-high
flush  in  1  synchronous flush, active-high (exception/branch kill)
in_valid  in  1  upstream payload valid
in_ready  out  1  stage can accept payload this cycle
in_data  in  DATA_W  upstream payload
in_ex  in  EX_W  upstream exception code
out_valid  out  1  output payload valid
out_ready  in  1  downstream accepts (0 = stall)
out_data  out  DATA_W  registered payload
out_ex  out  EX_W  registered exception code
stall_cnt  out  32  perf counter (see Optional Feature)
bubble_cnt  out  32  perf counter (see Optional Feature)

Behaviour:
- Reset (clr_n=0, async): out_valid=0, out_data=0, out_ex=0, skid empty and zeroed, counters 0. in_ready=1 on reset release.
- Accept: in_valid&in_ready at posedge. Drain: out_valid&out_ready at posedge.
- Invariant: out_valid=0 implies out_data=0 and out_ex=0 (bubble = NOP); registers zeroed on drain without refill.
- Priority per edge: clr_n > clr > flush > normal. clr and flush are identical for datapath: both valid bits cleared, all data/skid/ex zeroed, any same-cycle input discarded. Counters react only to clr (see below).
- SKID=1, states by (out_valid, skid_valid):
  EMPTY(0,0): accept -> BUSY, load out.
  BUSY(1,0): accept&drain -> BUSY, load out from input; accept&!drain -> FULL, input to skid; drain&!accept -> EMPTY; else hold.
  FULL(1,1): drain -> BUSY, skid moves to out, skid zeroed; else hold. No accept possible.
  in_ready = !skid_valid (pure register output, no combinational dependence on out_ready).
- SKID=0: in_ready = !out_valid | out_ready; accept loads out; drain without accept -> out_valid=0, zeroed. Skid logic absent.
- Latency: 1 cycle in->out when not stalled; throughput 1/cycle in both modes.
- Ordering strictly FIFO; no payload ever lost or duplicated except by flush/clr.
- Simultaneous flush and stall: flush wins; stage empty next cycle.
- Async reset mid-transfer: all state drops immediately; no partial payload survives.

Optional Feature:
Macro PIPE_STAGE_PERF_EN. Defined: stall_cnt increments each cycle out_valid&!out_ready; bubble_cnt increments each cycle !out_valid; both saturate at 32'hFFFF_FFFF, clear on clr_n or clr, unaffected by flush. Undefined: both ports driven constant 0, no counter flops.

Test Plan:
- Reset: clr_n=0 mid-stream with FULL state -> out_valid=0, out_data=0, in_ready=1 after release, counters 0.
- Streaming, SKID=1, out_ready=1: payloads 0x1..0x8 one per cycle -> emerge 0x1..0x8 on consecutive cycles, 1-cycle latency, in_ready held 1.
- Backpressure, SKID=1: send 0xA,0xB,0xC with out_ready=0 -> 0xA in out, 0xB in skid, in_ready=0 next cycle, 0xC held upstream; release out_ready -> 0xA,0xB,0xC in order, none lost.
- Flush in FULL with in_valid=1, in_data=0xD -> next cycle out_valid=0, out_data=0, out_ex=0, 0xD discarded, in_ready=1.
- SKID=0, out_ready toggling 1,0,1 with continuous input -> in_ready follows out_ready combinationally when out_valid=1; output sequence identical to input.
- PIPE_STAGE_PERF_EN: 3 stall cycles then 2 empty cycles, then flush -> stall_cnt=3, bubble_cnt increments through flush; clr -> both 0.

Source files
------------

// File: rtl/pipeline_stage_reg.sv
// Inter-stage pipeline register with valid/ready flow control.
// SKID=1 adds a second entry so in_ready comes straight from a flop.
// Optional perf counters are enabled by defining PIPE_STAGE_PERF_EN.
// clr and flush both turn the stage into a NOP bubble (all-zero payload).
module pipeline_stage_reg #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned EX_W   = 5,
    parameter int unsigned SKID   = 1
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              clr,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [EX_W-1:0]   in_ex,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [EX_W-1:0]   out_ex,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [EX_W-1:0]   out_ex_q, out_ex_d;
    logic              accept, drain, kill;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid_q & out_ready;
    assign kill   = clr | flush;

    // Output register; cleared by async reset.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ex_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ex_q    <= out_ex_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ex    = out_ex_q;

    if (SKID != 0) begin : gen_skid
        logic              skid_valid_q, skid_valid_d;
        logic [DATA_W-1:0] skid_data_q, skid_data_d;
        logic [EX_W-1:0]   skid_ex_q, skid_ex_d;

        // Skid entry register; holds the payload accepted while the output stalls.
        always_ff @(posedge clk or negedge clr_n) begin
            if (!clr_n) begin
                skid_valid_q <= 1'b0;
                skid_data_q  <= '0;
                skid_ex_q    <= '0;
            end else begin
                skid_valid_q <= skid_valid_d;
                skid_data_q  <= skid_data_d;
                skid_ex_q    <= skid_ex_d;
            end
        end

        // Ready depends only on skid occupancy, never on out_ready.
        assign in_ready = ~skid_valid_q;

        // Next state by (out_valid, skid_valid): EMPTY/BUSY/FULL.
        always_comb begin
            out_valid_d  = out_valid_q;
            out_data_d   = out_data_q;
            out_ex_d     = out_ex_q;
            skid_valid_d = skid_valid_q;
            skid_data_d  = skid_data_q;
            skid_ex_d    = skid_ex_q;
            if (kill) begin
                out_valid_d  = 1'b0;
                out_data_d   = '0;
                out_ex_d     = '0;
                skid_valid_d = 1'b0;
                skid_data_d  = '0;
                skid_ex_d    = '0;
            end else begin
                unique case ({out_valid_q, skid_valid_q})
                    2'b00: begin
                        if (accept) begin
                            out_valid_d = 1'b1;
                            out_data_d  = in_data;
                            out_ex_d    = in_ex;
                        end
                    end
                    2'b10: begin
                        if (accept && drain) begin
                            out_data_d = in_data;
                            out_ex_d   = in_ex;
                        end else if (accept) begin
                            skid_valid_d = 1'b1;
                            skid_data_d  = in_data;
                            skid_ex_d    = in_ex;
                        end else if (drain) begin
                            out_valid_d = 1'b0;
                            out_data_d  = '0;
                            out_ex_d    = '0;
                        end
                    end
                    2'b11: begin
                        if (drain) begin
                            out_data_d   = skid_data_q;
                            out_ex_d     = skid_ex_q;
                            skid_valid_d = 1'b0;
                            skid_data_d  = '0;
                            skid_ex_d    = '0;
                        end
                    end
                    default: begin
                        // Unreachable (skid full with output empty); recover to EMPTY.
                        out_valid_d  = 1'b0;
                        out_data_d   = '0;
                        out_ex_d     = '0;
                        skid_valid_d = 1'b0;
                        skid_data_d  = '0;
                        skid_ex_d    = '0;
                    end
                endcase
            end
        end
    end else begin : gen_no_skid
        assign in_ready = ~out_valid_q | out_ready;

        // Single register: load on accept, zero on drain without refill.
        always_comb begin
            out_valid_d = out_valid_q;
            out_data_d  = out_data_q;
            out_ex_d    = out_ex_q;
            if (kill) begin
                out_valid_d = 1'b0;
                out_data_d  = '0;
                out_ex_d    = '0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
                out_ex_d    = in_ex;
            end else if (drain) begin
                out_valid_d = 1'b0;
                out_data_d  = '0;
                out_ex_d    = '0;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_q, bubble_q;

    // Saturating perf counters; cleared by reset or clr, flush leaves them alone.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else if (clr) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid_q && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (!out_valid_q && (bubble_q != 32'hFFFF_FFFF)) begin
                bubble_q <= bubble_q + 32'd1;
            end
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = 32'd0;
    assign bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Directed bench for pipeline_stage_reg: table-driven SKID=1 vectors plus
// hand sequences for async reset and the SKID=0 variant.
module tb_pipeline_stage_reg;

    localparam int DW = 32;
    localparam int EW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          clr_n, clr, flush;
    logic          in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic [EW-1:0] in_ex;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [EW-1:0] out_ex;
    logic [31:0]   stall_cnt, bubble_cnt;

    logic          in_valid0, out_ready0;
    logic [DW-1:0] in_data0;
    logic [EW-1:0] in_ex0;
    logic          in_ready0, out_valid0;
    logic [DW-1:0] out_data0;
    logic [EW-1:0] out_ex0;
    logic [31:0]   stall_cnt0, bubble_cnt0;

    assign in_ex  = in_data[EW-1:0];
    assign in_ex0 = in_data0[EW-1:0];

    pipeline_stage_reg #(.DATA_W(DW), .EX_W(EW), .SKID(1)) dut (
        .clk(clk), .clr_n(clr_n), .clr(clr), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ex(in_ex),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ex(out_ex),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipeline_stage_reg #(.DATA_W(DW), .EX_W(EW), .SKID(0)) dut0 (
        .clk(clk), .clr_n(clr_n), .clr(clr), .flush(flush),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0), .in_ex(in_ex0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .out_ex(out_ex0), .stall_cnt(stall_cnt0), .bubble_cnt(bubble_cnt0)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          fl;
        logic          cl;
        logic          eov;
        logic [DW-1:0] eod;
        logic          eir;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic iv, input logic [DW-1:0] d, input logic ordy,
                                input logic fl, input logic cl, input logic eov,
                                input logic [DW-1:0] eod, input logic eir);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl; v.cl = cl;
        v.eov = eov; v.eod = eod; v.eir = eir;
        vecs.push_back(v);
    endfunction

    logic [31:0] m_stall, m_bubble;
    logic        prev_ov;

    initial begin
        logic          pat [12];
        logic [DW-1:0] q0[$];
        logic [DW-1:0] exp_d;
        logic          m_ov, acc, drn;
        int            drained;

        clr_n = 1'b0; clr = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b0;

        // Streaming 1..8 with out_ready=1
        for (int k = 1; k <= 8; k++) add(1, k, 1, 0, 0, 1, k, 1);
        add(0, 0, 1, 0, 0, 0, 0, 1);
        // Backpressure A,B,C then release
        add(1, 'hA, 0, 0, 0, 1, 'hA, 1);
        add(1, 'hB, 0, 0, 0, 1, 'hA, 0);
        add(1, 'hC, 0, 0, 0, 1, 'hA, 0);
        add(1, 'hC, 1, 0, 0, 1, 'hB, 1);
        add(1, 'hC, 1, 0, 0, 1, 'hC, 1);
        add(0, 0, 1, 0, 0, 0, 0, 1);
        // Flush in FULL with input 0xD pending
        add(1, 'hE, 0, 0, 0, 1, 'hE, 1);
        add(1, 'hF, 0, 0, 0, 1, 'hE, 0);
        add(1, 'hD, 0, 1, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 0, 1);
        // Flush in BUSY discards a same-cycle accept
        add(1, 'h51, 0, 0, 0, 1, 'h51, 1);
        add(1, 'h52, 1, 1, 0, 0, 0, 1);
        // clr discards a same-cycle accept
        add(1, 'h11, 0, 0, 0, 1, 'h11, 1);
        add(1, 'h12, 1, 0, 1, 0, 0, 1);
        // Perf: load, 3 stalls, drain, 2 empty, flush, clr
        add(1, 'h21, 0, 0, 0, 1, 'h21, 1);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 1, 'h21, 1);
        add(0, 0, 1, 0, 0, 0, 0, 1);
        for (int k = 0; k < 2; k++) add(0, 0, 1, 0, 0, 0, 0, 1);
        add(0, 0, 1, 1, 0, 0, 0, 1);
        add(0, 0, 1, 0, 1, 0, 0, 1);

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        @(negedge clk);
        clr_n = 1'b1;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'd1);
        check("rel_stall_cnt", 64'(stall_cnt), 64'd0);
        check("rel_bubble_cnt", 64'(bubble_cnt), 64'd0);

        m_stall = '0; m_bubble = '0; prev_ov = 1'b0;
        foreach (vecs[i]) begin
            in_valid = vecs[i].iv; in_data = vecs[i].d; out_ready = vecs[i].ordy;
            flush = vecs[i].fl; clr = vecs[i].cl;
            @(posedge clk);
            #1;
            if (vecs[i].cl) begin
                m_stall = '0; m_bubble = '0;
            end else begin
                if (prev_ov && !vecs[i].ordy) m_stall++;
                if (!prev_ov) m_bubble++;
            end
            prev_ov = vecs[i].eov;
            check($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].eov));
            check($sformatf("v%0d_out_data", i), 64'(out_data), 64'(vecs[i].eod));
            check($sformatf("v%0d_out_ex", i), 64'(out_ex), 64'(vecs[i].eod[EW-1:0]));
            check($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].eir));
`ifdef PIPE_STAGE_PERF_EN
            check($sformatf("v%0d_stall_cnt", i), 64'(stall_cnt), 64'(m_stall));
            check($sformatf("v%0d_bubble_cnt", i), 64'(bubble_cnt), 64'(m_bubble));
`else
            check($sformatf("v%0d_stall_cnt", i), 64'(stall_cnt), 64'd0);
            check($sformatf("v%0d_bubble_cnt", i), 64'(bubble_cnt), 64'd0);
`endif
        end
        flush = 1'b0; clr = 1'b0;

        // Async reset while FULL: state must drop without a clock edge.
        in_valid = 1'b1; in_data = 'h41; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_data = 'h42;
        @(posedge clk);
        #1;
        check("full_in_ready", 64'(in_ready), 64'd0);
        #2;
        clr_n = 1'b0;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_out_data", 64'(out_data), 64'd0);
        check("async_out_ex", 64'(out_ex), 64'd0);
        check("async_stall_cnt", 64'(stall_cnt), 64'd0);
        check("async_bubble_cnt", 64'(bubble_cnt), 64'd0);
        in_valid = 1'b0; in_data = '0;
        @(negedge clk);
        clr_n = 1'b1;
        #1;
        check("async_rel_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("async_no_survivor", 64'(out_valid), 64'd0);

        // SKID=0: continuous input, out_ready pattern, combinational in_ready.
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        m_ov = 1'b0; drained = 0; exp_d = 'h31;
        for (int k = 0; k < 12; k++) begin
            in_valid0 = (exp_d <= 'h38);
            in_data0 = exp_d;
            out_ready0 = pat[k];
            #1;
            check($sformatf("s0_c%0d_in_ready", k), 64'(in_ready0), 64'(!m_ov || pat[k]));
            acc = in_valid0 && (!m_ov || pat[k]);
            drn = m_ov && pat[k];
            if (drn) begin
                check($sformatf("s0_c%0d_out_data", k), 64'(out_data0), 64'(q0.pop_front()));
                drained++;
            end
            if (acc) begin
                q0.push_back(exp_d);
                exp_d++;
            end
            m_ov = acc || (m_ov && !drn);
            @(posedge clk);
            #1;
            check($sformatf("s0_c%0d_out_valid", k), 64'(out_valid0), 64'(m_ov));
            if (!m_ov) check($sformatf("s0_c%0d_zero", k), 64'(out_data0), 64'd0);
        end
        check("s0_drained", 64'(drained), 64'd8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global timeout so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1);
    end

endmodule
